inst_loader: RTL and testbench

- Write-side counterpart of the core's instruction fetch path. The core's instruction ROM is read-only from the core's side; this block is the writer that fills it.
- Accepts a byte stream holding a word count followed by 9-bit instructions packed two bytes each, and issues sequential write strobes into the instruction memory.
- Holds the core in reset via start for the whole load, then releases it.
- Sits between the host/test byte source and the instr_ROM write port plus the core start input.

---
 rtl/inst_loader_if.sv | 22 ++
 rtl/inst_loader.sv | 103 ++++++++++
 tb/tb_inst_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Byte-source handshake and instruction-memory write port for the loader.
// The master modport is the loader side, the slave modport the byte source and memory side.
interface inst_loader_if #(
    parameter int A = 16
) ();
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [8:0]   wr_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// Streams a length-prefixed image of 9-bit instructions into instruction memory.
// The core is held through start until the image is fully written.
module inst_loader #(
    parameter int A         = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load_go,
    inst_loader_if.master bus,
    output logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [A-1:0]  word_count
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_INST_LO, S_INST_HI,
        S_FLUSH, S_RELEASE, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] MAXW = 32'(MAX_WORDS);

    state_t      state, state_n;
    logic [15:0] len;
    logic [7:0]  lo;
    logic        wr_en_q;
    logic [8:0]  wr_data_q;
    logic        acc, wr_set, clr_cnt, last_word;
    logic [15:0] len_full;
    logic [31:0] cnt_ext;

    assign bus.in_ready = state inside {S_LEN_LO, S_LEN_HI, S_INST_LO, S_INST_HI};
    assign acc          = bus.in_valid & bus.in_ready;
    assign len_full     = {bus.in_data, len[7:0]};
    assign cnt_ext      = 32'(word_count);
    // A write never overlaps INST_HI, so word_count already counts every earlier word here.
    assign last_word    = (cnt_ext + 32'd1) == {16'd0, len};

    always_comb begin
        state_n = state;
        wr_set  = 1'b0;
        clr_cnt = 1'b0;
        case (state)
            S_IDLE:    if (load_go) state_n = S_LEN_LO;
            S_LEN_LO:  if (acc) state_n = S_LEN_HI;
            S_LEN_HI:
                if (acc) begin
                    if ({16'd0, len_full} > MAXW) state_n = S_ERR;
                    else if (len_full == 16'd0)   state_n = S_FLUSH;
                    else                          state_n = S_INST_LO;
                end
            S_INST_LO: if (acc) state_n = S_INST_HI;
            S_INST_HI:
                if (acc) begin
                    if (bus.in_data[7:1] != 7'd0) begin
                        state_n = S_ERR;
                    end else begin
                        wr_set  = 1'b1;
                        state_n = last_word ? S_FLUSH : S_INST_LO;
                    end
                end
            // FLUSH covers the final write cycle (or its empty slot when len is 0).
            S_FLUSH:   state_n = S_RELEASE;
            S_RELEASE: state_n = S_DONE;
            S_DONE, S_ERR:
                if (load_go) begin
                    state_n = S_LEN_LO;
                    clr_cnt = 1'b1;
                end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            len        <= '0;
            lo         <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            word_count <= '0;
        end else begin
            state   <= state_n;
            wr_en_q <= wr_set;
            if (acc && state == S_LEN_LO)  len[7:0]  <= bus.in_data;
            if (acc && state == S_LEN_HI)  len[15:8] <= bus.in_data;
            if (acc && state == S_INST_LO) lo        <= bus.in_data;
            if (wr_set) wr_data_q <= {bus.in_data[0], lo};
            if (clr_cnt)      word_count <= '0;
            else if (wr_en_q) word_count <= word_count + A'(1);
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = word_count;
    assign bus.wr_data = wr_data_q;

    assign start = (state != S_DONE);
    assign busy  = state inside {S_LEN_LO, S_LEN_HI, S_INST_LO, S_INST_HI, S_FLUSH, S_RELEASE};
    assign done  = (state == S_DONE);
    assign err   = (state == S_ERR);
endmodule

// File: tb/tb_inst_loader.sv
// Randomized bench for inst_loader: a load-level model predicts handshake, writes and status each cycle.
module tb_inst_loader;
    localparam int A = 16;

    logic clk = 1'b0, reset_n = 1'b0, load_go = 1'b0, load_go2 = 1'b0;
    logic start, busy, done, err, start2, busy2, done2, err2;
    logic [A-1:0] word_count, word_count2;

    inst_loader_if #(.A(A)) bus ();
    inst_loader_if #(.A(A)) bus2 ();

    inst_loader #(.A(A), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset_n(reset_n), .load_go(load_go), .bus(bus),
        .start(start), .busy(busy), .done(done), .err(err), .word_count(word_count));

    inst_loader #(.A(A), .MAX_WORDS(256)) dut2 (
        .clk(clk), .reset_n(reset_n), .load_go(load_go2), .bus(bus2),
        .start(start2), .busy(busy2), .done(done2), .err(err2), .word_count(word_count2));

    always #5 clk = ~clk;

    int vec = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load-level model: phase of the current load plus the bytes' meaning by position.
    typedef enum {P_IDLE, P_LOAD, P_OK, P_BAD} phase_t;
    phase_t     phase = P_IDLE;
    int         m_idx = 0, m_len = 0, m_issued = 0, m_cnt = 0, m_drain = 0, m_waddr = 0;
    logic [7:0] m_lo = '0, b;
    logic       m_wr = 1'b0;
    logic [8:0] m_wdata = '0;
    int         waddr_log[$];
    int         wdata_log[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            phase = P_IDLE; m_wr = 1'b0; m_cnt = 0; m_drain = 0; m_idx = 0;
        end else begin
            chk("wr_en", bus.wr_en, m_wr);
            if (bus.wr_en && m_wr) begin
                chk("wr_addr", bus.wr_addr, m_waddr);
                chk("wr_data", bus.wr_data, m_wdata);
            end
            if (bus.wr_en) begin
                waddr_log.push_back(int'(bus.wr_addr));
                wdata_log.push_back(int'(bus.wr_data));
            end
            chk("word_count", word_count, m_cnt);
            chk("in_ready", bus.in_ready, phase == P_LOAD);
            chk("busy", busy, (phase == P_LOAD) || (phase == P_OK && m_drain > 0));
            chk("start", start, !(phase == P_OK && m_drain == 0));
            chk("done", done, phase == P_OK && m_drain == 0);
            chk("err", err, phase == P_BAD);
            if (m_wr) m_cnt++;
            m_wr = 1'b0;
            if (m_drain > 0) begin
                m_drain--;
            end else if (phase != P_LOAD) begin
                if (load_go) begin
                    phase = P_LOAD; m_idx = 0; m_cnt = 0; m_issued = 0; m_len = 0;
                end
            end else if (bus.in_valid) begin
                b = bus.in_data;
                if (m_idx == 0) begin
                    m_len = int'(b);
                end else if (m_idx == 1) begin
                    m_len = m_len + int'(b) * 256;
                    if (m_len > 1024)    phase = P_BAD;
                    else if (m_len == 0) begin phase = P_OK; m_drain = 2; end
                end else if (m_idx % 2 == 0) begin
                    m_lo = b;
                end else if (b > 8'd1) begin
                    phase = P_BAD;
                end else begin
                    m_wr = 1'b1; m_waddr = m_issued; m_wdata = {b[0], m_lo};
                    m_issued++;
                    if (m_issued == m_len) begin phase = P_OK; m_drain = 2; end
                end
                m_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic go();
        load_go = 1'b1; tick(); load_go = 1'b0;
    endtask

    task automatic send(input logic [7:0] q[$], input bit rnd);
        foreach (q[i]) begin
            int guard = 0;
            bit acc = 1'b0;
            while (!acc) begin
                bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data  = bus.in_valid ? q[i] : 8'($urandom);
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                tick();
                guard++;
                if (!acc && guard > 60) begin
                    chk("accept_timeout", 32'(guard), 32'd0);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the final byte.
    task automatic expect_done(input int wc);
        @(negedge clk); chk("lat_c1_start", start, 1); chk("lat_c1_busy", busy, 1);
        @(negedge clk); chk("lat_c2_start", start, 1); chk("lat_c2_busy", busy, 1);
        @(negedge clk); chk("lat_c3_start", start, 0); chk("lat_c3_done", done, 1);
        chk("final_wc", word_count, wc);
        tick();
    endtask

    task automatic chk_wr(input int k, input int addr, input int data);
        if (k >= waddr_log.size()) begin
            chk("write_missing", 32'(waddr_log.size()), 32'(k + 1));
        end else begin
            chk("log_addr", waddr_log[k], addr);
            chk("log_data", wdata_log[k], data);
        end
    endtask

    logic [7:0] s3[$];
    logic [7:0] sb[$];
    logic [7:0] sl[$];
    int exp_d[$];
    int base;

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus2.in_valid = 1'b0; bus2.in_data = '0;
        s3 = '{8'h03, 8'h00, 8'h2A, 8'h00, 8'hFF, 8'h01, 8'h40, 8'h00};
        tick(); tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_start", start, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_in_ready", bus.in_ready, 0); chk("rst_wc", word_count, 0);
        tick();

        // three words, valid held high
        base = waddr_log.size();
        go(); send(s3, 1'b0); expect_done(3);
        chk_wr(base, 0, 'h02A); chk_wr(base + 1, 1, 'h1FF); chk_wr(base + 2, 2, 'h040);
        chk("t1_nwr", 32'(waddr_log.size() - base), 3);

        // same stream, valid toggling
        base = waddr_log.size();
        go(); send(s3, 1'b1); expect_done(3);
        chk_wr(base, 0, 'h02A); chk_wr(base + 1, 1, 'h1FF); chk_wr(base + 2, 2, 'h040);
        chk("t2_nwr", 32'(waddr_log.size() - base), 3);

        // empty image
        base = waddr_log.size();
        sl = '{8'h00, 8'h00};
        go(); send(sl, 1'b0); expect_done(0);
        chk("t3_nwr", 32'(waddr_log.size() - base), 0);

        // 260 words of random instructions
        base = waddr_log.size();
        sl = '{8'h04, 8'h01};
        exp_d.delete();
        for (int i = 0; i < 260; i++) begin
            logic [8:0] w;
            w = 9'($urandom);
            exp_d.push_back(int'(w));
            sl.push_back(w[7:0]);
            sl.push_back({7'd0, w[8]});
        end
        go(); send(sl, 1'b1); expect_done(260);
        chk("t4_nwr", 32'(waddr_log.size() - base), 260);
        for (int i = 0; i < 260; i++) chk_wr(base + i, i, exp_d[i]);

        // length 260 exceeds a 256-word limit
        load_go2 = 1'b1; tick(); load_go2 = 1'b0;
        bus2.in_valid = 1'b1; bus2.in_data = 8'h04; tick();
        bus2.in_data = 8'h01; tick();
        @(negedge clk);
        chk("max_err", err2, 1); chk("max_start", start2, 1);
        chk("max_in_ready", bus2.in_ready, 0); chk("max_busy", busy2, 0);
        tick(); tick();
        @(negedge clk); chk("max_in_ready_later", bus2.in_ready, 0);
        tick();
        bus2.in_valid = 1'b0;

        // bad high byte in word 2, then recovery
        base = waddr_log.size();
        sb = '{8'h03, 8'h00, 8'h2A, 8'h00, 8'hFF, 8'h01, 8'h40, 8'h03};
        go(); send(sb, 1'b1);
        @(negedge clk);
        chk("bad_err", err, 1); chk("bad_wc", word_count, 2);
        chk("bad_start", start, 1); chk("bad_done", done, 0);
        tick(); tick();
        chk("bad_nwr", 32'(waddr_log.size() - base), 2);
        base = waddr_log.size();
        sl = '{8'h01, 8'h00, 8'h55, 8'h01};
        go(); send(sl, 1'b0); expect_done(1);
        chk_wr(base, 0, 'h155);

        // reset mid-load
        sl = '{8'h05, 8'h00, 8'h11};
        go(); send(sl, 1'b0);
        reset_n = 1'b0; #1;
        chk("mid_rst_start", start, 1); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_en", bus.wr_en, 0); chk("mid_rst_wc", word_count, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("post_rst_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        base = waddr_log.size();
        sl = '{8'h01, 8'h00, 8'h07, 8'h00};
        go(); send(sl, 1'b1); expect_done(1);
        chk_wr(base, 0, 'h007);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
